inst_axi_bridge: RTL and testbench

Responder for the fetch stage's instruction request interface: accepts `inst_req`/`inst_addr` with an `inst_addr_ok` handshake, issues single-beat AXI4 read transactions, and returns instruction words to the pipeline in request order with an `inst_data_ok` pulse. It sits between the fetch stage (and its IF_wait stage) and the AXI crossbar, and serves both cached and uncached fetch addresses already translated to physical.

---
 rtl/inst_axi_bridge.sv | 111 +++++++++++
 tb/tb_inst_axi_bridge.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_axi_bridge.sv
// ---------------------------------------------------------------------------
// inst_axi_bridge
//   Turns fetch-stage instruction requests into single-beat AXI4 reads. It
//   returns the words to the pipeline in request order.
//
//   Parameters
//     DEPTH : maximum outstanding requests (accepted, not yet returned), 1..7
//     ARID  : constant read ID driven on arid
//
//   Ports
//     clk, resetn                    : clock, asynchronous active-low reset
//     inst_req/inst_cache/inst_addr  : fetch request, cacheable flag, address
//     inst_addr_ok                   : request accepted this cycle (comb.)
//     inst_data_ok/inst_rdata        : returned word, one pulse per request
//     inst_data_err                  : rresp[1] of the returning beat
//     ar*                            : AXI read-address channel (master)
//     r*                             : AXI read-data channel (master)
// ---------------------------------------------------------------------------
module inst_axi_bridge #(
    parameter int         DEPTH = 2,
    parameter logic [3:0] ARID  = 4'd0
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_cache,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    output logic        inst_data_err,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [3:0]  arcache,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    logic [2:0] cnt;
    logic       ar_free;
    logic       accept;
    logic       retire;

    // Single ID means AXI returns beats in issue order, so rid carries no
    // information here; rresp[0] only separates OKAY from EXOKAY.
    logic unused_r;
    assign unused_r = ^{rid, rresp[0]};

    assign arid    = ARID;
    assign arlen   = 8'd0;
    assign arsize  = 3'd2;
    assign arburst = 2'b01;

    // A new address may only be loaded once the AR slot is empty or is being
    // handed off this cycle, so araddr never changes under a pending arvalid.
    assign ar_free      = !arvalid || arready;
    assign inst_addr_ok = inst_req && ar_free && (cnt < DEPTH_C);
    assign accept       = inst_addr_ok;

    assign rready = (cnt != 3'd0);
    assign retire = rvalid && rready && rlast;

    // AR channel and outstanding count
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arvalid <= 1'b0;
            araddr  <= 32'd0;
            arcache <= 4'd0;
            cnt     <= 3'd0;
        end else begin
            if (accept) begin
                araddr  <= inst_addr;
                arcache <= inst_cache ? 4'b1111 : 4'b0000;
                arvalid <= 1'b1;
            end else if (arvalid && arready) begin
                arvalid <= 1'b0;
            end
            cnt <= cnt + {2'd0, accept} - {2'd0, retire};
        end
    end

    // R beat -> registered return to the fetch stage
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_data_ok  <= 1'b0;
            inst_rdata    <= 32'd0;
            inst_data_err <= 1'b0;
        end else begin
            inst_data_ok <= retire;
            if (retire) begin
                inst_rdata    <= rdata;
                inst_data_err <= rresp[1];
            end
        end
    end

endmodule

// File: tb/tb_inst_axi_bridge.sv
module tb_inst_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_cache;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok, inst_data_err;
    logic [31:0] inst_rdata;
    logic [3:0]  arid, arcache;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    inst_axi_bridge #(.DEPTH(2), .ARID(4'd0)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_cache(inst_cache), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata), .inst_data_err(inst_data_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arcache(arcache), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic cache; } req_t;
    typedef struct { logic [31:0] addr; int due; } beat_t;

    req_t        req_q[$];   // requests waiting to be presented
    req_t        ar_q[$];    // accepted, AR handshake expected
    logic [31:0] exp_q[$];   // scoreboard: accepted, data_ok expected
    beat_t       sl_q[$];    // slave: AR taken, R beat pending
    int acc_log[$], ar_log[$], ret_log[$], dok_log[$];

    int checks = 0, fails = 0;
    int cyc_n = 0, lat = 1, ar_block = 0, outstanding = 0, max_out = 0, stall_cnt = 0;
    logic spur = 1'b0;
    logic last_err;
    logic [31:0] last_rdata;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        if (a == 32'h1FC0_0000) return 32'h3C1D_BFC0;
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
    endfunction

    function automatic logic is_err(logic [31:0] a);
        return a == 32'h0040_0000;
    endfunction

    function automatic int qat(int q[$], int i);
        return (q.size() > i) ? q[i] : -100;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        if (req_q.size() > 0) begin
            inst_req   = 1'b1;
            inst_addr  = req_q[0].addr;
            inst_cache = req_q[0].cache;
        end else begin
            inst_req   = 1'b0;
            inst_addr  = 32'd0;
            inst_cache = 1'b0;
        end
    endtask

    task automatic clear_logs();
        acc_log.delete(); ar_log.delete(); ret_log.delete(); dok_log.delete();
        max_out = 0; stall_cnt = 0;
    endtask

    // One clock: observe at the falling edge, update stimulus after the rise.
    task automatic cyc();
        req_t r;
        beat_t b;
        logic [31:0] a;
        @(negedge clk);
        if (resetn) begin
            if (inst_data_ok) begin
                dok_log.push_back(cyc_n);
                outstanding--;
                last_rdata = inst_rdata;
                last_err   = inst_data_err;
                chk("data_ok_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    a = exp_q.pop_front();
                    chk("rdata", inst_rdata, mem_word(a));
                    chk("data_err", 32'(inst_data_err), 32'(is_err(a)));
                end
            end
            if (inst_addr_ok) begin
                chk("addr_ok_needs_req", 32'(inst_req), 32'd1);
                ar_q.push_back('{inst_addr, inst_cache});
                exp_q.push_back(inst_addr);
                acc_log.push_back(cyc_n);
                outstanding++;
                if (outstanding > max_out) max_out = outstanding;
                if (req_q.size() > 0) void'(req_q.pop_front());
            end
            if (arvalid && !arready) begin
                stall_cnt++;
                chk("addr_ok_during_stall", 32'(inst_addr_ok), 32'd0);
                if (ar_q.size() > 0) chk("araddr_stable", araddr, ar_q[0].addr);
            end
            if (arvalid && arready) begin
                ar_log.push_back(cyc_n);
                chk("ar_expected", 32'(ar_q.size() > 0), 32'd1);
                if (ar_q.size() > 0) begin
                    r = ar_q.pop_front();
                    chk("araddr", araddr, r.addr);
                    chk("arcache", 32'(arcache), r.cache ? 32'hF : 32'h0);
                    chk("ar_const", {arid, arlen, 1'b0, arsize, 2'b0, arburst, 12'd0},
                        {4'd0, 8'd0, 1'b0, 3'd2, 2'b0, 2'b01, 12'd0});
                end
                sl_q.push_back('{araddr, cyc_n + lat});
            end
            if (rvalid && rready && rlast) begin
                ret_log.push_back(cyc_n);
                chk("r_handshake_expected", 32'(sl_q.size() > 0), 32'd1);
                if (sl_q.size() > 0) void'(sl_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (ar_block > 0) ar_block--;
        arready = (ar_block == 0);
        if (sl_q.size() > 0 && sl_q[0].due <= cyc_n) begin
            b      = sl_q[0];
            rvalid = 1'b1;
            rdata  = mem_word(b.addr);
            rresp  = is_err(b.addr) ? 2'b10 : 2'b00;
            rlast  = 1'b1;
        end else if (spur) begin
            rvalid = 1'b1;
            rdata  = 32'hDEAD_BEEF;
            rresp  = 2'b00;
            rlast  = 1'b1;
        end else begin
            rvalid = 1'b0;
            rdata  = 32'd0;
            rresp  = 2'b00;
            rlast  = 1'b0;
        end
        drive();
    endtask

    task automatic run_idle(string tag, int limit);
        int n = 0;
        while ((req_q.size() > 0 || exp_q.size() > 0 || sl_q.size() > 0) && n < limit) begin
            cyc();
            n++;
        end
        chk(tag, 32'(n < limit), 32'd1);
        cyc();
    endtask

    task automatic push_req(logic [31:0] a, logic c);
        req_q.push_back('{a, c});
    endtask

    initial begin
        resetn = 1'b0; inst_req = 1'b0; inst_cache = 1'b0; inst_addr = 32'd0;
        arready = 1'b1; rid = 4'd0; rdata = 32'd0; rresp = 2'b00;
        rlast = 1'b0; rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_arcache", 32'(arcache), 32'd0);
        chk("rst_data_ok", 32'(inst_data_ok), 32'd0);
        chk("rst_rdata", inst_rdata, 32'd0);
        chk("rst_err", 32'(inst_data_err), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        resetn = 1'b1;

        // Single uncached fetch, R one cycle after AR
        clear_logs(); lat = 1;
        push_req(32'h1FC0_0000, 1'b0); drive();
        run_idle("t1_timeout", 20);
        chk("t1_n_data_ok", 32'(dok_log.size()), 32'd1);
        chk("t1_ar_cycle", 32'(qat(ar_log, 0)), 32'(qat(acc_log, 0) + 1));
        chk("t1_dok_cycle", 32'(qat(dok_log, 0)), 32'(qat(acc_log, 0) + 3));
        chk("t1_rdata", last_rdata, 32'h3C1D_BFC0);
        chk("t1_err", 32'(last_err), 32'd0);

        // Cached stream, latency 5, depth 2
        clear_logs(); lat = 5;
        for (int i = 0; i < 4; i++) push_req(32'(i * 4), 1'b1);
        drive();
        run_idle("t2_timeout", 60);
        chk("t2_n_data_ok", 32'(dok_log.size()), 32'd4);
        chk("t2_max_outstanding", 32'(max_out), 32'd2);
        chk("t2_third_accept", 32'(qat(acc_log, 2)), 32'(qat(ret_log, 0) + 1));

        // arready low for 4 cycles after accept
        clear_logs(); lat = 1;
        push_req(32'h0000_2000, 1'b0); push_req(32'h0000_2004, 1'b0);
        ar_block = 5; arready = 1'b0; drive();
        run_idle("t3_timeout", 40);
        chk("t3_stall_cycles", 32'(stall_cnt), 32'd4);
        chk("t3_ar_cycle", 32'(qat(ar_log, 0)), 32'(qat(acc_log, 0) + 5));
        chk("t3_next_accept", 32'(qat(acc_log, 1)), 32'(qat(ar_log, 0)));
        chk("t3_n_data_ok", 32'(dok_log.size()), 32'd2);

        // Error response
        clear_logs(); lat = 2;
        push_req(32'h0040_0000, 1'b0); drive();
        run_idle("t4_timeout", 20);
        chk("t4_n_data_ok", 32'(dok_log.size()), 32'd1);
        chk("t4_err", 32'(last_err), 32'd1);
        chk("t4_rready_idle", 32'(rready), 32'd0);

        // Spurious rvalid while nothing is outstanding
        clear_logs(); spur = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5_rready", 32'(rready), 32'd0);
        end
        spur = 1'b0;
        cyc(); cyc();
        chk("t5_no_data_ok", 32'(dok_log.size()), 32'd0);
        push_req(32'h0000_3000, 1'b1); drive();
        run_idle("t5_timeout", 20);
        chk("t5_after_n_data_ok", 32'(dok_log.size()), 32'd1);

        // Reset with two outstanding and arvalid pending
        clear_logs(); lat = 20;
        push_req(32'h0000_0100, 1'b1); push_req(32'h0000_0104, 1'b1); drive();
        for (int i = 0; i < 20 && acc_log.size() < 2; i++) cyc();
        chk("t6_two_accepted", 32'(acc_log.size()), 32'd2);
        ar_block = 1000; arready = 1'b0;
        cyc();
        chk("t6_arvalid_before", 32'(arvalid), 32'd1);
        chk("t6_rready_before", 32'(rready), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("t6_arvalid", 32'(arvalid), 32'd0);
        chk("t6_araddr", araddr, 32'd0);
        chk("t6_arcache", 32'(arcache), 32'd0);
        chk("t6_rready", 32'(rready), 32'd0);
        chk("t6_data_ok", 32'(inst_data_ok), 32'd0);
        chk("t6_rdata", inst_rdata, 32'd0);
        chk("t6_err", 32'(inst_data_err), 32'd0);
        req_q.delete(); ar_q.delete(); exp_q.delete(); sl_q.delete();
        outstanding = 0; ar_block = 0; arready = 1'b1; lat = 1;
        rvalid = 1'b0; rlast = 1'b0; drive();
        cyc();
        resetn = 1'b1;
        clear_logs();
        push_req(32'h1FC0_0004, 1'b0); drive();
        run_idle("t6_timeout", 20);
        chk("t6_after_n_data_ok", 32'(dok_log.size()), 32'd1);
        chk("t6_after_dok_cycle", 32'(qat(dok_log, 0)), 32'(qat(acc_log, 0) + 3));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
